// File: rtl/div_unit.sv
// div_unit: multi-cycle integer divide unit for the execute stage.
// Implements the two ALU operations the single-cycle ALU lacks:
//   DIV  (alu_control 3'b011): signed quotient, truncated toward zero
//   REMU (alu_control 3'b100): unsigned remainder
// A radix-2 restoring divider produces one quotient bit per cycle.
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-high reset
//   start, alu_control   - request, qualified by a DIV/REMU opcode
//   dividend, divisor    - rs1 / rs2 operands
//   result               - registered quotient or remainder, held until next load
//   busy                 - high while iterating (CALC)
//   done                 - one-cycle pulse; result valid from this cycle on
//   stall                - freezes fetch/decode/execute pipeline registers
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] rem, rem_next;       // partial remainder
  logic [WIDTH-1:0] quo, quo_next;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs, dvs_next;       // divisor magnitude
  logic [WIDTH-1:0] result_next;
  logic [CW-1:0]    count, count_next;
  logic             is_div, is_div_next;
  logic             neg, neg_next;

  // Request decode
  logic op_div, op_remu, req;
  logic div_zero, overflow, special;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_div   = (alu_control == 3'b011);
  assign op_remu  = (alu_control == 3'b100);
  assign req      = start && (op_div || op_remu);
  assign div_zero = (divisor == '0);
  assign overflow = op_div && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
  assign special  = div_zero || overflow;

  // Only DIV takes magnitudes; REMU operands are already unsigned.
  assign a_neg = op_div && dividend[WIDTH-1];
  assign b_neg = op_div && divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  // One restoring step. The shifted remainder needs WIDTH+1 bits because
  // an unsigned divisor may use the full width; since rem < dvs the shifted
  // value stays below 2*dvs, so bit WIDTH of the difference is the borrow.
  logic [WIDTH:0]   partial, diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_step, quo_step, quo_signed;

  assign partial    = {rem, quo[WIDTH-1]};
  assign diff       = partial - {1'b0, dvs};
  assign borrow     = diff[WIDTH];
  assign rem_step   = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step   = {quo[WIDTH-2:0], ~borrow};
  assign quo_signed = neg ? -quo_step : quo_step;

  always_comb begin
    state_next  = state;
    rem_next    = rem;
    quo_next    = quo;
    dvs_next    = dvs;
    count_next  = count;
    is_div_next = is_div;
    neg_next    = neg;
    result_next = result;
    stall       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (special) begin
            // DIV by zero gives all ones; REMU by zero and DIV overflow
            // both return the dividend unchanged.
            result_next = (op_div && div_zero) ? '1 : dividend;
            state_next  = DONE;
          end else begin
            rem_next    = '0;
            quo_next    = a_mag;
            dvs_next    = b_mag;
            count_next  = CW'(WIDTH - 1);
            is_div_next = op_div;
            neg_next    = a_neg ^ b_neg;
            state_next  = CALC;
          end
        end
      end
      CALC: begin
        stall      = 1'b1;
        rem_next   = rem_step;
        quo_next   = quo_step;
        count_next = count - 1'b1;
        if (count == '0) begin
          result_next = is_div ? quo_signed : rem_step;
          state_next  = DONE;
        end
      end
      DONE: begin
        // start is ignored here so the instruction still in execute
        // is not issued a second time.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset forces the pipeline free even if a request is presented.
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      count  <= '0;
      is_div <= 1'b0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_next;
      rem    <= rem_next;
      quo    <= quo_next;
      dvs    <= dvs_next;
      count  <= count_next;
      is_div <= is_div_next;
      neg    <= neg_next;
      result <= result_next;
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit (WIDTH=32).
// A cycle-level behavioural model (accept time, latency, arithmetic result)
// is checked against the DUT on every falling edge; directed transactions
// additionally check hand-computed results and latencies.
module tb_div_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_REMU = 3'b100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   alu_control = 3'b000;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic [W-1:0] result;
  logic         busy, done, stall;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .dividend(dividend), .divisor(divisor),
    .result(result), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, b);
    longint sa, sb, q;
    logic [63:0] qv;
    if (op == OP_DIV) begin
      if (b == '0) return '1;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;               // SV integer division truncates toward zero
      qv = q;
      return qv[W-1:0];
    end
    if (b == '0) return a;
    return a % b;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [W-1:0] a, b);
    return (b == '0) || (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic bit valid_req(input logic s, input logic [2:0] op);
    return s && (op == OP_DIV || op == OP_REMU);
  endfunction

  // ---------------- cycle model ----------------
  // m_cyc counts cycles since the accepting edge; m_lat is the cycle in
  // which done must appear (1 for special cases, W+1 otherwise).
  bit           m_active = 1'b0;
  int           m_cyc = 0;
  int           m_lat = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_cyc    <= 0;
      m_lat    <= 0;
      m_result <= '0;
    end else if (m_active) begin
      if (m_cyc == m_lat) m_active <= 1'b0;
      else begin
        m_cyc <= m_cyc + 1;
        if (m_cyc + 1 == m_lat) m_result <= m_pend;
      end
    end else if (valid_req(start, alu_control)) begin
      m_active <= 1'b1;
      m_cyc    <= 1;
      m_pend   <= ref_res(alu_control, dividend, divisor);
      if (is_special(alu_control, dividend, divisor)) begin
        m_lat    <= 1;
        m_result <= ref_res(alu_control, dividend, divisor);
      end else begin
        m_lat <= W + 1;
      end
    end
  end

  logic e_done, e_busy, e_stall;
  assign e_done  = m_active && (m_cyc == m_lat);
  assign e_busy  = m_active && (m_cyc < m_lat);
  assign e_stall = !rst && ((!m_active && valid_req(start, alu_control)) || e_busy);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model done",   {31'b0, done},  {31'b0, e_done});
    chk("model busy",   {31'b0, busy},  {31'b0, e_busy});
    chk("model stall",  {31'b0, stall}, {31'b0, e_stall});
    chk("model result", result, m_result);
  end

  // ---------------- transaction driver ----------------
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, exp_r,
                        input int exp_lat, input bit hold, input string name);
    int n;
    bit seen;
    @(posedge clk); #2;                 // cycle 0: request presented
    start = 1'b1; alu_control = op; dividend = a; divisor = b;
    @(posedge clk); #2;                 // cycle 1
    if (!hold) begin start = 1'b0; alu_control = 3'b000; end
    seen = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #2;
      if (hold) begin dividend = $urandom; divisor = $urandom; end
    end
    chk({name, " done seen"}, {31'b0, seen}, 32'd1);
    chk({name, " latency"}, 32'(n), 32'(exp_lat));
    chk({name, " result"}, result, exp_r);
    $display("txn %s op=%b a=%h b=%h result=%h done_cycle=%0d", name, op, a, b, result, n);
    if (hold) begin @(posedge clk); #2; start = 1'b0; alu_control = 3'b000; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] op;
    logic [W-1:0] a, b;
    int sel;

    #1;
    chk("reset result", result, 32'h0);
    chk("reset busy",  {31'b0, busy},  32'd0);
    chk("reset done",  {31'b0, done},  32'd0);
    chk("reset stall", {31'b0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Directed, hand-computed expectations
    run_op(OP_DIV,  32'd100,       32'd7,         32'd14,        W + 1, 1'b0, "div_100_7");
    run_op(OP_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, W + 1, 1'b0, "div_m100_7");
    run_op(OP_REMU, 32'd100,       32'd7,         32'd2,         W + 1, 1'b0, "remu_100_7");
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'd16,        32'd15,        W + 1, 1'b0, "remu_max_16");
    run_op(OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1,     1'b0, "div_by_zero");
    run_op(OP_REMU, 32'd5,         32'd0,         32'd5,         1,     1'b0, "remu_by_zero");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,     1'b0, "div_overflow");
    run_op(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, W + 1, 1'b1, "div_7_m2_hold");
    run_op(OP_REMU, 32'd9,         32'd0,         32'd9,         1,     1'b1, "remu_zero_hold");

    // Non-DIV/REMU opcode must not request
    @(posedge clk); #2;
    start = 1'b1; alu_control = 3'b000; dividend = 32'd50; divisor = 32'd5;
    #1 chk("ignored op stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #2;
    chk("ignored op busy", {31'b0, busy}, 32'd0);
    start = 1'b0;
    $display("txn ignored_op op=000 stall=%b busy=%b", stall, busy);

    // Reset in cycle 10 of a DIV
    @(posedge clk); #2;
    start = 1'b1; alu_control = OP_DIV; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #2;
    start = 1'b0; alu_control = 3'b000;
    repeat (9) @(posedge clk);
    #2;
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort busy",   {31'b0, busy},  32'd0);
    chk("abort done",   {31'b0, done},  32'd0);
    chk("abort stall",  {31'b0, stall}, 32'd0);
    chk("abort result", result, 32'd0);
    $display("txn reset_abort busy=%b done=%b stall=%b result=%h", busy, done, stall, result);
    @(posedge clk); #2 rst = 1'b0;
    run_op(OP_DIV, 32'd9, 32'd3, 32'd3, W + 1, 1'b0, "div_9_3_after_reset");

    // Randomised transactions checked against the reference arithmetic
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 5) ? OP_DIV : (sel < 9) ? OP_REMU : 3'($urandom_range(5, 7));
      a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = '1;
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (op == OP_DIV || op == OP_REMU) begin
        run_op(op, a, b, ref_res(op, a, b), is_special(op, a, b) ? 1 : W + 1,
               1'($urandom_range(0, 1)), "random");
      end else begin
        @(posedge clk); #2;
        start = 1'b1; alu_control = op; dividend = a; divisor = b;
        @(posedge clk); #2;
        start = 1'b0; alu_control = 3'b000;
        $display("txn random_ignored op=%b busy=%b", op, busy);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
